// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register: NFIELD packed DW-bit fields with valid/ready, stall hold,
// flush-to-bubble (optional PC retention) and a saturating stall counter. Define SKID_BUF_EN
// for a one-entry skid buffer with a registered in_ready.

module pipe_stage_field #(
  parameter int DW   = 32,
  parameter bit KEEP = 1'b0
)(
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          load_main,
  input  logic          load_skid,
  input  logic          sel_skid,
  input  logic [DW-1:0] in_field,
  output logic [DW-1:0] out_field
);
  logic [DW-1:0] main_src;

`ifdef SKID_BUF_EN
  logic [DW-1:0] skid_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           skid_q <= '0;
    else if (flush)     skid_q <= '0;
    else if (load_skid) skid_q <= in_field;
  end

  assign main_src = sel_skid ? skid_q : in_field;
`else
  logic unused_skid;
  assign unused_skid = load_skid ^ sel_skid;
  assign main_src    = in_field;
`endif

  // A flush bubbles the slot; the PC field may survive for exception/redirect use.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) out_field <= '0;
    else if (flush) begin
      if (!KEEP) out_field <= '0;
    end
    else if (load_main) out_field <= main_src;
  end
endmodule

module pipe_stage_reg #(
  parameter int DW            = 32,
  parameter int NFIELD        = 6,
  parameter int PC_IDX        = 0,
  parameter int FLUSH_KEEP_PC = 1,
  parameter int CNT_W         = 16
)(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NFIELD*DW-1:0] in_data,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NFIELD*DW-1:0] out_data,
  output logic [CNT_W-1:0]     stall_cnt
);
  logic [NFIELD-1:0][DW-1:0] in_fields, out_fields;
  logic load, load_main, load_skid, sel_skid, main_free, stalled;

  assign in_fields = in_data;
  assign out_data  = out_fields;
  assign main_free = !out_valid | out_ready;
  assign stalled   = out_valid & !out_ready;
  assign load      = in_valid & in_ready;

`ifdef SKID_BUF_EN
  logic skid_valid;

  // in_ready depends only on state (and flush), never on out_ready.
  assign in_ready  = !skid_valid & !flush;
  assign sel_skid  = skid_valid;
  assign load_main = skid_valid ? main_free : (load & main_free);
  assign load_skid = load & !main_free;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                      skid_valid <= 1'b0;
    else if (flush)                skid_valid <= 1'b0;
    else if (load_skid)            skid_valid <= 1'b1;
    else if (sel_skid & load_main) skid_valid <= 1'b0;
  end
`else
  assign in_ready  = main_free & !flush;
  assign sel_skid  = 1'b0;
  assign load_main = load;
  assign load_skid = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           out_valid <= 1'b0;
    else if (flush)     out_valid <= 1'b0;
    else if (load_main) out_valid <= 1'b1;
    else if (out_ready) out_valid <= 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                          stall_cnt <= '0;
    else if (stalled && ~&stall_cnt)   stall_cnt <= stall_cnt + 1'b1;
  end

  for (genvar k = 0; k < NFIELD; k++) begin : g_field
    pipe_stage_field #(
      .DW   (DW),
      .KEEP ((FLUSH_KEEP_PC != 0) && (k == PC_IDX))
    ) u_field (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .load_main (load_main),
      .load_skid (load_skid),
      .sel_skid  (sel_skid),
      .in_field  (in_fields[k]),
      .out_field (out_fields[k])
    );
  end
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench for pipe_stage_reg: a default-parameter instance plus a
// small instance (FLUSH_KEEP_PC=0, CNT_W=4) for zero-flush and counter saturation.

module tb_pipe_stage_reg;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // instance 0: defaults (DW=32, NFIELD=6, PC_IDX=0, keep PC, CNT_W=16)
  logic         in_valid0 = 1'b0, in_ready0, flush0 = 1'b0, out_valid0, out_ready0 = 1'b0;
  logic [191:0] in_data0 = '0, out_data0;
  logic [15:0]  stall_cnt0;

  // instance 1: two fields, PC in field 1, flush zeroes everything, 4-bit counter
  logic         in_valid1 = 1'b0, in_ready1, flush1 = 1'b0, out_valid1, out_ready1 = 1'b0;
  logic [63:0]  in_data1 = '0, out_data1;
  logic [3:0]   stall_cnt1;

  pipe_stage_reg u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0), .in_data(in_data0),
    .flush(flush0), .out_valid(out_valid0), .out_ready(out_ready0), .out_data(out_data0),
    .stall_cnt(stall_cnt0)
  );

  pipe_stage_reg #(.DW(32), .NFIELD(2), .PC_IDX(1), .FLUSH_KEEP_PC(0), .CNT_W(4)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
    .flush(flush1), .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
    .stall_cnt(stall_cnt1)
  );

  function automatic logic [191:0] mk(input logic [31:0] pc, input logic [31:0] ir);
    logic [191:0] d;
    d = '0;
    d[0*32 +: 32] = pc;
    d[1*32 +: 32] = ir;
    for (int k = 2; k < 6; k++) d[k*32 +: 32] = (pc + 32'(k * 256)) ^ 32'hA5A5_0000;
    return d;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out0(input string tag, input logic v, input logic [31:0] pc, input logic [31:0] ir);
    logic [191:0] e;
    e = mk(pc, ir);
    chk({tag, "_valid"}, 64'(out_valid0), 64'(v));
    chk({tag, "_pc"},    64'(out_data0[31:0]),   64'(pc));
    chk({tag, "_ir"},    64'(out_data0[63:32]),  64'(ir));
    chk({tag, "_f3"},    64'(out_data0[127:96]), 64'(e[127:96]));
  endtask

  initial begin
    // reset with the clock running
    step(); step();
    chk("rst_valid0", 64'(out_valid0), 64'd0);
    chk("rst_data0_lo", out_data0[63:0], 64'd0);
    chk("rst_data0_hi", out_data0[191:128], 64'd0);
    chk("rst_cnt0", 64'(stall_cnt0), 64'd0);
    chk("rst_valid1", 64'(out_valid1), 64'd0);
    chk("rst_data1", out_data1, 64'd0);
    chk("rst_cnt1", 64'(stall_cnt1), 64'd0);
    rst = 1'b1;
    #1;
    chk("rst_in_ready0", 64'(in_ready0), 64'd1);
    chk("rst_in_ready1", 64'(in_ready1), 64'd1);

    // stream three back-to-back items
    out_ready0 = 1'b1; in_valid0 = 1'b1;
    in_data0 = mk(32'h3000, 32'h1111_0000); step();
    chk_out0("s0", 1'b1, 32'h3000, 32'h1111_0000);
    in_data0 = mk(32'h3004, 32'h1111_0004); step();
    chk_out0("s1", 1'b1, 32'h3004, 32'h1111_0004);
    in_data0 = mk(32'h3008, 32'h1111_0008); step();
    chk_out0("s2", 1'b1, 32'h3008, 32'h1111_0008);
    in_valid0 = 1'b0; step();
    chk("drain_valid", 64'(out_valid0), 64'd0);
    chk("drain_pc_held", 64'(out_data0[31:0]), 64'h3008);
    chk("stream_cnt", 64'(stall_cnt0), 64'd0);

    // stall for four cycles
    in_valid0 = 1'b1; in_data0 = mk(32'h3010, 32'h2222_0010); step();
    chk_out0("stl_load", 1'b1, 32'h3010, 32'h2222_0010);
    in_valid0 = 1'b0; out_ready0 = 1'b0; #1;
`ifdef SKID_BUF_EN
    chk("stl_in_ready", 64'(in_ready0), 64'd1);
`else
    chk("stl_in_ready", 64'(in_ready0), 64'd0);
`endif
    for (int i = 0; i < 4; i++) begin
      step();
      chk_out0("stl_hold", 1'b1, 32'h3010, 32'h2222_0010);
    end
    chk("stl_cnt4", 64'(stall_cnt0), 64'd4);
    out_ready0 = 1'b1; in_valid0 = 1'b1; in_data0 = mk(32'h3018, 32'h2222_0018); #1;
    chk("rel_in_ready", 64'(in_ready0), 64'd1);
    step();
    chk_out0("rel_load", 1'b1, 32'h3018, 32'h2222_0018);
    chk("rel_cnt", 64'(stall_cnt0), 64'd4);
    in_valid0 = 1'b0; step();
    chk("rel_drain", 64'(out_valid0), 64'd0);

    // flush while stalled, PC kept
    in_valid0 = 1'b1; in_data0 = mk(32'h3020, 32'h8C01_0004); step();
    chk_out0("fl_load", 1'b1, 32'h3020, 32'h8C01_0004);
    in_valid0 = 1'b0; out_ready0 = 1'b0; step();
    chk("fl_cnt5", 64'(stall_cnt0), 64'd5);
    flush0 = 1'b1; in_valid0 = 1'b1; in_data0 = mk(32'h3024, 32'h9999_9999); #1;
    chk("fl_in_ready", 64'(in_ready0), 64'd0);
    step();
    chk("fl_valid", 64'(out_valid0), 64'd0);
    chk("fl_pc_kept", 64'(out_data0[31:0]), 64'h3020);
    chk("fl_ir_zero", 64'(out_data0[63:32]), 64'd0);
    chk("fl_hi_zero", out_data0[191:128], 64'd0);
    chk("fl_cnt6", 64'(stall_cnt0), 64'd6);
    flush0 = 1'b0; in_valid0 = 1'b0; step();
    chk("fl_after_valid", 64'(out_valid0), 64'd0);
    chk("fl_after_cnt", 64'(stall_cnt0), 64'd6);
    chk("fl_after_in_ready", 64'(in_ready0), 64'd1);

    // ordering across a stall with a second item pending
    out_ready0 = 1'b1; in_valid0 = 1'b1; in_data0 = mk(32'h3040, 32'h4444_0040); step();
    chk_out0("ord_a", 1'b1, 32'h3040, 32'h4444_0040);
    out_ready0 = 1'b0; in_data0 = mk(32'h3044, 32'h4444_0044); step();
    chk_out0("ord_hold", 1'b1, 32'h3040, 32'h4444_0040);
    chk("ord_in_ready", 64'(in_ready0), 64'd0);
    chk("ord_cnt7", 64'(stall_cnt0), 64'd7);
    out_ready0 = 1'b1; step();
    chk_out0("ord_b", 1'b1, 32'h3044, 32'h4444_0044);
    in_valid0 = 1'b0; step();
    chk("ord_empty", 64'(out_valid0), 64'd0);
    chk("ord_cnt_final", 64'(stall_cnt0), 64'd7);

    // asynchronous reset in the middle of a stall
    in_valid0 = 1'b1; in_data0 = mk(32'h3030, 32'h5555_0030); step();
    in_valid0 = 1'b0; out_ready0 = 1'b0; step();
    chk("ars_cnt8", 64'(stall_cnt0), 64'd8);
    #2 rst = 1'b0;
    #1;
    chk("ars_valid", 64'(out_valid0), 64'd0);
    chk("ars_data", out_data0[63:0], 64'd0);
    chk("ars_cnt", 64'(stall_cnt0), 64'd0);
    step();
    rst = 1'b1; step();

    // instance 1: saturation and zeroing flush
    in_valid1 = 1'b1; in_data1 = {32'h3050, 32'h1234}; out_ready1 = 1'b0; step();
    chk("sat_load_valid", 64'(out_valid1), 64'd1);
    chk("sat_load_data", out_data1, {32'h3050, 32'h1234});
    in_valid1 = 1'b0;
    for (int i = 0; i < 14; i++) step();
    chk("sat_cnt14", 64'(stall_cnt1), 64'd14);
    step();
    chk("sat_cnt15", 64'(stall_cnt1), 64'd15);
    for (int i = 0; i < 5; i++) step();
    chk("sat_cnt_hold", 64'(stall_cnt1), 64'd15);
    chk("sat_data_hold", out_data1, {32'h3050, 32'h1234});
    flush1 = 1'b1; step();
    flush1 = 1'b0;
    chk("fz_valid", 64'(out_valid1), 64'd0);
    chk("fz_data", out_data1, 64'd0);
    chk("fz_cnt", 64'(stall_cnt1), 64'd15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
